// File: rtl/timer_array.sv
// timer_array: N-channel reloadable up-counter timers with prescale or cascade clocking
//   clock_16      system clock
//   reset         asynchronous active-low reset
//   reload_we     per-channel reload write strobe, data on reload_wdata
//   ctrl_we       per-channel control write strobe, data on ctrl_wdata
//                 ctrl: [1:0] prescale sel, [2] cascade, [6] irq_en, [7] enable
//   count_out     live counters, channel i at [i*CNT_W +: CNT_W]
//   ctrl_out      control register readback, channel i at [i*8 +: 8]
//   overflow      registered one-cycle pulse the cycle after a channel wraps
//   irq           overflow gated by irq_en, same timing as overflow
module timer_array #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
) (
    input  logic                    clock_16,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       reload_we,
    input  logic [CNT_W-1:0]        reload_wdata,
    input  logic [NUM_CH-1:0]       ctrl_we,
    input  logic [7:0]              ctrl_wdata,
    output logic [NUM_CH*CNT_W-1:0] count_out,
    output logic [NUM_CH*8-1:0]     ctrl_out,
    output logic [NUM_CH-1:0]       overflow,
    output logic [NUM_CH-1:0]       irq
);
    genvar i;
    generate
        for (i = 0; i < NUM_CH; i++) begin : ch
            logic [CNT_W-1:0] rld, cnt, nrld;
            logic [7:0]       ctl;
            logic [9:0]       psc, mask;
            logic             casc, run, rise, tick, cin, inc, wrap, ovf_q, irq_q;
            // Cascade input is the previous channel's same-cycle wrap, so chains ripple combinationally.
            if (i == 0) begin : g_first
                assign cin = 1'b0;
            end else begin : g_next
                assign cin = ch[i-1].wrap;
            end
            assign casc = (i != 0) && ctl[2];
            // A write that clears enable freezes the channel in that very cycle.
            assign run  = ctl[7] && !(ctrl_we[i] && !ctrl_wdata[7]);
            assign rise = ctrl_we[i] && ctrl_wdata[7] && !ctl[7];
            assign mask = (ctl[1:0] == 2'd0) ? 10'd0 :
                          (ctl[1:0] == 2'd1) ? 10'd63 :
                          (ctl[1:0] == 2'd2) ? 10'd255 : 10'd1023;
            assign tick = (psc & mask) == mask;
            assign inc  = run && (casc ? cin : tick);
            assign wrap = inc && (cnt == {CNT_W{1'b1}});
            // Write-through: a reload written this cycle is what a wrap or enable rise loads.
            assign nrld = reload_we[i] ? reload_wdata : rld;
            always_ff @(posedge clock_16 or negedge reset) begin
                if (!reset) begin
                    rld   <= '0;
                    cnt   <= '0;
                    ctl   <= '0;
                    psc   <= '0;
                    ovf_q <= 1'b0;
                    irq_q <= 1'b0;
                end else begin
                    if (reload_we[i]) rld <= reload_wdata;
                    if (ctrl_we[i]) ctl <= ctrl_wdata;
                    ovf_q <= wrap;
                    irq_q <= wrap && ctl[6];
                    if (rise) begin
                        cnt <= nrld;
                        psc <= '0;
                    end else begin
                        if (run && !casc) psc <= psc + 10'd1;
                        if (wrap) cnt <= nrld;
                        else if (inc) cnt <= cnt + 1'b1;
                    end
                end
            end
            assign count_out[i*CNT_W +: CNT_W] = cnt;
            assign ctrl_out[i*8 +: 8]          = ctl;
            assign overflow[i]                 = ovf_q;
            assign irq[i]                      = irq_q;
        end
    endgenerate
endmodule

// File: tb/tb_timer_array.sv
// tb_timer_array: directed self-checking bench for timer_array
module tb_timer_array;
    localparam int N = 4;
    localparam int W = 16;
    logic             clock_16 = 1'b0;
    logic             reset = 1'b0;
    logic [N-1:0]     reload_we = '0;
    logic [W-1:0]     reload_wdata = '0;
    logic [N-1:0]     ctrl_we = '0;
    logic [7:0]       ctrl_wdata = '0;
    logic [N*W-1:0]   count_out;
    logic [N*8-1:0]   ctrl_out;
    logic [N-1:0]     overflow;
    logic [N-1:0]     irq;
    int total = 0;
    int bad = 0;

    timer_array #(.NUM_CH(N), .CNT_W(W)) dut (
        .clock_16(clock_16), .reset(reset),
        .reload_we(reload_we), .reload_wdata(reload_wdata),
        .ctrl_we(ctrl_we), .ctrl_wdata(ctrl_wdata),
        .count_out(count_out), .ctrl_out(ctrl_out),
        .overflow(overflow), .irq(irq)
    );

    always #5 clock_16 = ~clock_16;

    task automatic step(int n = 1);
        repeat (n) @(posedge clock_16);
        #1;
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(logic [N-1:0] rwe, logic [W-1:0] rd, logic [N-1:0] cwe, logic [7:0] cd);
        reload_we = rwe;
        reload_wdata = rd;
        ctrl_we = cwe;
        ctrl_wdata = cd;
        step();
        reload_we = '0;
        ctrl_we = '0;
    endtask

    function automatic logic [W-1:0] cnt(int c);
        return count_out[c*W +: W];
    endfunction

    initial begin
        step(2);
        chk("rst_count", count_out, 0);
        chk("rst_ctrl", ctrl_out, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_irq", irq, 0);
        reset = 1'b1;
        step();
        // T1: /1 wrap with reload 0xFFFC
        wr(4'b0001, 16'hFFFC, 4'b0001, 8'h80);
        chk("t1_load", cnt(0), 16'hFFFC);
        step();
        chk("t1_c1", cnt(0), 16'hFFFD);
        step();
        chk("t1_c2", cnt(0), 16'hFFFE);
        step();
        chk("t1_c3", cnt(0), 16'hFFFF);
        chk("t1_noovf", overflow, 0);
        step();
        chk("t1_wrap", cnt(0), 16'hFFFC);
        chk("t1_ovf", overflow, 4'b0001);
        chk("t1_irq", irq, 0);
        step();
        chk("t1_ovf_end", overflow, 0);
        chk("t1_c5", cnt(0), 16'hFFFD);
        wr(4'b0000, 16'h0, 4'b0001, 8'h00);
        chk("t1_freeze", cnt(0), 16'hFFFD);
        step();
        chk("t1_hold", cnt(0), 16'hFFFD);
        chk("t1_ctrl", ctrl_out[7:0], 8'h00);
        // T2: /64 with irq, reload 0xFFFF
        wr(4'b0001, 16'hFFFF, 4'b0001, 8'hC1);
        chk("t2_load", cnt(0), 16'hFFFF);
        step(63);
        chk("t2_early", overflow, 0);
        step();
        chk("t2_ovf1", overflow, 4'b0001);
        chk("t2_irq1", irq, 4'b0001);
        chk("t2_cnt", cnt(0), 16'hFFFF);
        step();
        chk("t2_gap", overflow, 0);
        step(62);
        chk("t2_early2", irq, 0);
        step();
        chk("t2_ovf2", overflow, 4'b0001);
        chk("t2_irq2", irq, 4'b0001);
        wr(4'b0000, 16'h0, 4'b0001, 8'h00);
        // T3: ch1 cascaded from ch0
        wr(4'b0010, 16'hFFFF, 4'b0010, 8'h84);
        chk("t3_c1load", cnt(1), 16'hFFFF);
        wr(4'b0001, 16'hFFFE, 4'b0001, 8'h80);
        chk("t3_c0load", cnt(0), 16'hFFFE);
        chk("t3_c1idle", cnt(1), 16'hFFFF);
        step();
        chk("t3_s1", overflow, 0);
        step();
        chk("t3_s2", overflow, 4'b0011);
        chk("t3_s2c0", cnt(0), 16'hFFFE);
        step();
        chk("t3_s3", overflow, 0);
        step();
        chk("t3_s4", overflow, 4'b0011);
        wr(4'b0000, 16'h0, 4'b0010, 8'h00);
        chk("t3_c0run", cnt(0), 16'hFFFF);
        step();
        chk("t3_nocasc", overflow, 4'b0001);
        wr(4'b0000, 16'h0, 4'b0001, 8'h00);
        chk("t3_off", overflow, 0);
        chk("t3_c0frz", cnt(0), 16'hFFFE);
        // T4: ch2 disable and re-enable
        wr(4'b0100, 16'h1230, 4'b0100, 8'h80);
        step(4);
        chk("t4_run", cnt(2), 16'h1234);
        wr(4'b0000, 16'h0, 4'b0100, 8'h00);
        chk("t4_dis", cnt(2), 16'h1234);
        step(3);
        chk("t4_hold", cnt(2), 16'h1234);
        wr(4'b0100, 16'h0010, 4'b0100, 8'h80);
        chk("t4_reen", cnt(2), 16'h0010);
        step();
        chk("t4_inc", cnt(2), 16'h0011);
        chk("t4_ctrl", ctrl_out[23:16], 8'h80);
        // T5: reload race against wrap
        wr(4'b0000, 16'h0, 4'b0001, 8'h80);
        chk("t5_load", cnt(0), 16'hFFFE);
        step();
        chk("t5_max", cnt(0), 16'hFFFF);
        wr(4'b0001, 16'h8000, 4'b0000, 8'h00);
        chk("t5_race", cnt(0), 16'h8000);
        chk("t5_ovf", overflow[0], 1'b1);
        step();
        chk("t5_after", cnt(0), 16'h8001);
        wr(4'b0001, 16'h1111, 4'b0000, 8'h00);
        chk("t5_nowrap", cnt(0), 16'h8002);
        step();
        chk("t5_next", cnt(0), 16'h8003);
        // T6: continuous wrap on ch3, then reset mid-operation
        wr(4'b1000, 16'hFFFF, 4'b1000, 8'hC0);
        chk("t6_load", overflow[3], 1'b0);
        step();
        chk("t6_ovf", overflow[3], 1'b1);
        chk("t6_irq", irq[3], 1'b1);
        step();
        chk("t6_cont", overflow[3] & irq[3], 1'b1);
        reset = 1'b0;
        #1;
        chk("t6_rcnt", count_out, 0);
        chk("t6_rovf", overflow, 0);
        chk("t6_rirq", irq, 0);
        chk("t6_rctl", ctrl_out, 0);
        step();
        reset = 1'b1;
        step(2);
        chk("t6_postovf", overflow, 0);
        chk("t6_postirq", irq, 0);
        chk("t6_postcnt", count_out, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
